// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM state encoding and
// the per-op EXEC cycle count.
package alu_seq_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StLoadA,
      StLoadB,
      StExec,
      StOutHi,
      StOutLo
   } state_t;

   // DIV spends one extra cycle correcting a negative remainder.
   function automatic int unsigned exec_cycles(logic [1:0] op, int unsigned width);
      unique case (op)
         OP_MUL:  return width;
         OP_DIV:  return width + 1;
         default: return 1;
      endcase
   endfunction

endpackage

// File: rtl/alu_seq_w_if.sv
// Operand/result bus between the sequencing driver (master) and the ALU (slave).
interface alu_seq_w_if #(
   parameter int unsigned WIDTH = 8
);
   logic             BEGIN;
   logic [1:0]       op_code;
   logic [WIDTH-1:0] inbus;
   logic [WIDTH-1:0] outbus;
   logic             out_valid;
   logic             END;
   logic             busy;
   logic             overflow;
   logic             div_zero;

   modport master (
      output BEGIN, op_code, inbus,
      input  outbus, out_valid, END, busy, overflow, div_zero
   );

   modport slave (
      input  BEGIN, op_code, inbus,
      output outbus, out_valid, END, busy, overflow, div_zero
   );
endinterface

// File: rtl/alu_iter_core.sv
// Iterative MUL/DIV datapath: shift-add (or Booth when ALU_SIGNED_MUL_EN is
// defined) multiply and non-restoring unsigned divide sharing one register pair.
module alu_iter_core #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             init_i,
   input  logic             step_i,
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [CNT_W-1:0] cnt_o
);

   // acc holds the partial remainder (signed, W+2 bits) for DIV; for MUL the
   // low W bits are the upper product half and the MSB carries the Booth bit.
   logic [WIDTH+1:0] acc_q, acc_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   mul_t;
   logic [WIDTH+1:0] b_ext, div_sh, div_r;

   always_comb begin
      b_ext = {2'b00, b_i};
`ifdef ALU_SIGNED_MUL_EN
      unique case ({lo_q[0], acc_q[WIDTH+1]})
         2'b01:   mul_t = {acc_q[WIDTH-1], acc_q[WIDTH-1:0]} + {b_i[WIDTH-1], b_i};
         2'b10:   mul_t = {acc_q[WIDTH-1], acc_q[WIDTH-1:0]} - {b_i[WIDTH-1], b_i};
         default: mul_t = {acc_q[WIDTH-1], acc_q[WIDTH-1:0]};
      endcase
`else
      mul_t = {1'b0, acc_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, b_i} : '0);
`endif
      div_sh = {acc_q[WIDTH:0], lo_q[WIDTH-1]};
      div_r  = acc_q[WIDTH+1] ? div_sh + b_ext : div_sh - b_ext;

      acc_d = acc_q;
      lo_d  = lo_q;
      cnt_d = cnt_q;
      if (init_i) begin
         acc_d = '0;
         lo_d  = a_i;
         cnt_d = '0;
      end else if (step_i) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (!is_div_i) begin
            acc_d = {lo_q[0], 1'b0, mul_t[WIDTH:1]};
            lo_d  = {mul_t[0], lo_q[WIDTH-1:1]};
         end else if (cnt_q == CNT_W'(WIDTH)) begin
            if (acc_q[WIDTH+1]) acc_d = acc_q + b_ext;
         end else begin
            acc_d = div_r;
            lo_d  = {lo_q[WIDTH-2:0], ~div_r[WIDTH+1]};
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         acc_q <= '0;
         lo_q  <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_d;
      end
   end

   assign hi_o  = acc_q[WIDTH-1:0];
   assign lo_o  = lo_q;
   assign cnt_o = cnt_q;

endmodule

// File: rtl/alu_seq_w.sv
// Multi-cycle ADD/SUB/MUL/DIV engine with BEGIN/END handshake and a serial
// operand bus. ALU_SIGNED_MUL_EN selects signed (Booth) multiplication.
module alu_seq_w
   import alu_seq_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic        clk,
   input  logic        reset,
   alu_seq_w_if.slave  bus
);

   state_t           state_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, res_hi_q, res_lo_q;
   logic             valid_q, end_q, busy_q, ovf_q, dz_q;

   logic [WIDTH:0]   sum_w;
   logic             ovf_w;
   logic [WIDTH-1:0] core_hi, core_lo;
   logic [CNT_W-1:0] core_cnt;
   logic             exec_last, from_core;

   alu_iter_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .clk_i    (clk),
      .rst_ni   (reset),
      .init_i   (state_q == StLoadB),
      .step_i   ((state_q == StExec) && op_q[1]),
      .is_div_i (op_q == OP_DIV),
      .a_i      (a_q),
      .b_i      (b_q),
      .hi_o     (core_hi),
      .lo_o     (core_lo),
      .cnt_o    (core_cnt)
   );

   always_comb begin
      sum_w = '0;
      ovf_w = 1'b0;
      if (op_q == OP_SUB) begin
         sum_w = {1'b0, a_q} - {1'b0, b_q};
         ovf_w = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
      end else begin
         sum_w = {1'b0, a_q} + {1'b0, b_q};
         ovf_w = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
      end
   end

   assign exec_last = core_cnt == CNT_W'(exec_cycles(op_q, WIDTH) - 1);
   // Divide-by-zero bypasses the core, so its result lives in res_*_q.
   assign from_core = op_q[1] && !dz_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         valid_q  <= 1'b0;
         end_q    <= 1'b0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.BEGIN) begin
                  op_q    <= bus.op_code;
                  ovf_q   <= 1'b0;
                  dz_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= StLoadA;
               end
            end
            StLoadA: begin
               a_q     <= bus.inbus;
               state_q <= StLoadB;
            end
            StLoadB: begin
               b_q <= bus.inbus;
               if ((op_q == OP_DIV) && (bus.inbus == '0)) begin
                  dz_q     <= 1'b1;
                  res_hi_q <= a_q;
                  res_lo_q <= '1;
                  valid_q  <= 1'b1;
                  state_q  <= StOutHi;
               end else begin
                  state_q  <= StExec;
               end
            end
            StExec: begin
               if (!op_q[1]) begin
                  res_hi_q <= {{(WIDTH-1){1'b0}}, sum_w[WIDTH]};
                  res_lo_q <= sum_w[WIDTH-1:0];
                  ovf_q    <= ovf_w;
               end
               if (exec_last) begin
                  valid_q <= 1'b1;
                  state_q <= StOutHi;
               end
            end
            StOutHi: begin
               end_q   <= 1'b1;
               state_q <= StOutLo;
            end
            StOutLo: begin
               valid_q <= 1'b0;
               end_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      bus.outbus = '0;
      if (state_q == StOutHi) bus.outbus = from_core ? core_hi : res_hi_q;
      else if (state_q == StOutLo) bus.outbus = from_core ? core_lo : res_lo_q;
   end

   assign bus.out_valid = valid_q;
   assign bus.END       = end_q;
   assign bus.busy      = busy_q;
   assign bus.overflow  = ovf_q;
   assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_alu_seq_w.sv
// Directed self-checking bench for alu_seq_w at WIDTH=8.
module tb_alu_seq_w;
   import alu_seq_pkg::*;

   localparam int W = 8;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   alu_seq_w_if #(.WIDTH(W)) bus ();

   alu_seq_w #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Edge T0 accepts BEGIN; at the negedge after edge Tk, END high means END is
   // sampled at edge T(k+1).
   task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input int exp_end,
                         input logic exp_ovf, input logic exp_dz, input bit disturb);
      int k;
      int end_t;
      int extra;
      bit got_end;
      logic [W-1:0] hi_seen;
      logic [W-1:0] lo_seen;
      logic ovf_seen, dz_seen, busy_seen;
      @(negedge clk);
      bus.BEGIN = 1'b1;
      bus.op_code = op;
      @(negedge clk);
      bus.BEGIN = 1'b0;
      bus.inbus = a;
      @(negedge clk);
      bus.inbus = b;
      k = 1;
      end_t = 0;
      got_end = 1'b0;
      hi_seen = 'x;
      lo_seen = 'x;
      ovf_seen = 1'bx;
      dz_seen = 1'bx;
      busy_seen = 1'bx;
      while (!got_end && k < 60) begin
         @(negedge clk);
         k++;
         if (disturb && (k == 2 || k == 6)) begin
            bus.BEGIN = 1'b1;
            bus.op_code = OP_DIV;
            bus.inbus = W'($urandom);
         end else begin
            bus.BEGIN = 1'b0;
         end
         if (bus.out_valid && !bus.END) hi_seen = bus.outbus;
         if (bus.END) begin
            got_end = 1'b1;
            end_t = k + 1;
            lo_seen = bus.outbus;
            ovf_seen = bus.overflow;
            dz_seen = bus.div_zero;
            busy_seen = bus.busy;
         end
      end
      bus.BEGIN = 1'b0;
      check({tag, "_end_time"}, 32'(end_t), 32'(exp_end));
      check({tag, "_hi"}, 32'(hi_seen), 32'(exp_hi));
      check({tag, "_lo"}, 32'(lo_seen), 32'(exp_lo));
      check({tag, "_ovf"}, 32'(ovf_seen), 32'(exp_ovf));
      check({tag, "_dz"}, 32'(dz_seen), 32'(exp_dz));
      check({tag, "_busy_at_end"}, 32'(busy_seen), 32'd1);
      @(negedge clk);
      check({tag, "_idle_end"}, 32'(bus.END), 32'd0);
      check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_idle_outbus"}, 32'(bus.outbus), 32'd0);
      if (disturb) begin
         extra = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.END) extra++;
         end
         check({tag, "_extra_ends"}, 32'(extra), 32'd0);
      end
   endtask

   initial begin
      int ends;
      checks = 0;
      failures = 0;
      reset = 1'b0;
      bus.BEGIN = 1'b0;
      bus.op_code = OP_ADD;
      bus.inbus = '0;
      repeat (3) @(negedge clk);
      check("rst_outbus", 32'(bus.outbus), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_end", 32'(bus.END), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_ovf", 32'(bus.overflow), 32'd0);
      check("rst_dz", 32'(bus.div_zero), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      run_op("add_100_100", OP_ADD, 8'd100, 8'd100, 8'h00, 8'hC8, 5, 1'b1, 1'b0, 1'b0);
      run_op("add_127_0", OP_ADD, 8'd127, 8'd0, 8'h00, 8'h7F, 5, 1'b0, 1'b0, 1'b0);
      run_op("sub_5_7", OP_SUB, 8'd5, 8'd7, 8'h01, 8'hFE, 5, 1'b0, 1'b0, 1'b0);
      run_op("sub_80_01", OP_SUB, 8'h80, 8'h01, 8'h00, 8'h7F, 5, 1'b1, 1'b0, 1'b0);
      run_op("mul_7_3", OP_MUL, 8'd7, 8'd3, 8'h00, 8'h15, 12, 1'b0, 1'b0, 1'b0);
`ifdef ALU_SIGNED_MUL_EN
      run_op("mul_ff_ff", OP_MUL, 8'hFF, 8'hFF, 8'h00, 8'h01, 12, 1'b0, 1'b0, 1'b0);
`else
      run_op("mul_ff_ff", OP_MUL, 8'hFF, 8'hFF, 8'hFE, 8'h01, 12, 1'b0, 1'b0, 1'b0);
`endif
      run_op("div_100_7", OP_DIV, 8'd100, 8'd7, 8'h02, 8'h0E, 13, 1'b0, 1'b0, 1'b0);
      run_op("div_255_1", OP_DIV, 8'd255, 8'd1, 8'h00, 8'hFF, 13, 1'b0, 1'b0, 1'b0);
      run_op("div_7_100", OP_DIV, 8'd7, 8'd100, 8'h07, 8'h00, 13, 1'b0, 1'b0, 1'b0);
      run_op("div_9_0", OP_DIV, 8'd9, 8'd0, 8'h09, 8'hFF, 4, 1'b0, 1'b1, 1'b0);
      run_op("mul_busy_begin", OP_MUL, 8'd7, 8'd3, 8'h00, 8'h15, 12, 1'b0, 1'b0, 1'b1);

      // Reset sampled at edge T6 of a MUL.
      @(negedge clk);
      bus.BEGIN = 1'b1;
      bus.op_code = OP_MUL;
      @(negedge clk);
      bus.BEGIN = 1'b0;
      bus.inbus = 8'd7;
      @(negedge clk);
      bus.inbus = 8'd3;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_outbus", 32'(bus.outbus), 32'd0);
      check("midrst_end", 32'(bus.END), 32'd0);
      check("midrst_valid", 32'(bus.out_valid), 32'd0);
      reset = 1'b1;
      ends = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.END) ends++;
      end
      check("midrst_no_end", 32'(ends), 32'd0);
      run_op("add_1_1", OP_ADD, 8'd1, 8'd1, 8'h00, 8'h02, 5, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
